// File: rtl/pwm_command_guard.sv
// pwm_command_guard: clamps, slew-limits and end-stop-guards a signed PWM duty
// command for one axis, and ramps the drive to zero when commands stop arriving.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | out of reset, no command seen yet; target held at 0
// RUN     | commands arriving; watchdog counting cycles since last one
// TIMEOUT | watchdog expired; target forced to 0 until next command
module pwm_command_guard #(
    parameter int MAX_COUNT  = 4096,
    parameter int SLEW_STEP  = 16,
    parameter int SLEW_DIV   = 500,
    parameter int WDT_CYCLES = 5_000_000,
    parameter int POS_LO     = 1000,
    parameter int POS_HI     = 63000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic signed [15:0] cmd_duty,
    input  logic        [15:0] position,
    output logic signed [15:0] duty_out,
    output logic               timeout,
    output logic               limit_hit,
    output logic        [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_TIMEOUT = 2'b10
    } state_t;

    // All duty arithmetic is done in 17 bits so target - duty_out cannot wrap.
    localparam logic signed [16:0] MAX_P     = 17'(MAX_COUNT);
    localparam logic signed [16:0] MIN_P     = 17'(-MAX_COUNT);
    localparam logic signed [16:0] STEP_P    = 17'(SLEW_STEP);
    localparam logic signed [16:0] NEG_STEP  = 17'(-SLEW_STEP);
    localparam logic        [31:0] SLEW_LAST = 32'(SLEW_DIV - 1);
    localparam logic        [31:0] WDT_LAST  = 32'(WDT_CYCLES - 1);
    localparam logic        [15:0] POS_LO_U  = 16'(POS_LO);
    localparam logic        [15:0] POS_HI_U  = 16'(POS_HI);

    state_t             state_q;
    state_t             state_d;
    logic signed [16:0] cmd_ext;
    logic signed [16:0] cmd_clamped;
    logic signed [16:0] target_q;
    logic signed [16:0] eff_target;
    logic signed [16:0] duty_ext;
    logic signed [16:0] diff;
    logic signed [16:0] slewed;
    logic        [31:0] slew_cnt;
    logic        [31:0] wdt_cnt;
    logic               tick;
    logic               wdt_expire;
    logic               at_hi;
    logic               at_lo;
    logic               duty_pos;
    logic               duty_neg;
    logic               tgt_pos;
    logic               tgt_neg;
    logic               stop_duty;
    logic               stop_target;

    assign tick       = (slew_cnt == SLEW_LAST);
    assign wdt_expire = (state_q == ST_RUN) && !cmd_valid && (wdt_cnt == WDT_LAST);

    assign at_hi    = (position >= POS_HI_U);
    assign at_lo    = (position <= POS_LO_U);
    assign duty_ext = {duty_out[15], duty_out};
    assign duty_pos = !duty_out[15] && (duty_out != '0);
    assign duty_neg = duty_out[15];
    assign tgt_pos  = !target_q[16] && (target_q != '0);
    assign tgt_neg  = target_q[16];

    // Drive already heading into a stop is cut immediately; a target pointing
    // into the stop is masked to zero so the slew cannot re-apply it.
    assign stop_duty   = (at_hi && duty_pos) || (at_lo && duty_neg);
    assign stop_target = (at_hi && tgt_pos) || (at_lo && tgt_neg);
    assign eff_target  = stop_target ? '0 : target_q;

    assign timeout = (state_q == ST_TIMEOUT);
    assign state   = state_q;

    // Sign-extend and saturate the incoming command.
    always_comb begin
        cmd_ext     = {cmd_duty[15], cmd_duty};
        cmd_clamped = cmd_ext;
        if (cmd_ext > MAX_P) begin
            cmd_clamped = MAX_P;
        end else if (cmd_ext < MIN_P) begin
            cmd_clamped = MIN_P;
        end
    end

    // Next slew value: jump to the target when within one step, else step toward it.
    always_comb begin
        diff   = eff_target - duty_ext;
        slewed = eff_target;
        if (diff > STEP_P) begin
            slewed = duty_ext + STEP_P;
        end else if (diff < NEG_STEP) begin
            slewed = duty_ext + NEG_STEP;
        end
    end

    // Next-state logic; a command on the expiry cycle keeps the FSM in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_valid) state_d = ST_RUN;
            ST_RUN:     if (wdt_expire) state_d = ST_TIMEOUT;
            ST_TIMEOUT: if (cmd_valid) state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Free-running slew prescaler; tick on its terminal count.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            slew_cnt <= '0;
        end else begin
            slew_cnt <= slew_cnt + 32'd1;
        end
    end

    // Watchdog counts only in RUN and restarts on every command.
    always_ff @(posedge clk) begin
        if (rst || cmd_valid || wdt_expire || (state_q != ST_RUN)) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end

    // Target register: loaded by commands, zeroed on watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
        end else if (cmd_valid) begin
            target_q <= cmd_clamped;
        end else if (wdt_expire) begin
            target_q <= '0;
        end
    end

    // Output duty: end-stop cut overrides the slew step.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_out <= '0;
        end else if (stop_duty) begin
            duty_out <= '0;
        end else if (tick) begin
            duty_out <= slewed[15:0];
        end
    end

    // End-stop flag follows the stop condition one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_hit <= 1'b0;
        end else begin
            limit_hit <= stop_duty || stop_target;
        end
    end

endmodule
